// File: rtl/miso_fifo_pack_pkg.sv
// Shared router package: precision-mode encoding and the number of stored
// entries each mode packs into a single output word.
package miso_fifo_pack_pkg;

    // Precision of each packed field in the output word; 2'b11 is reserved.
    typedef enum logic [1:0] {
        P_8B = 2'b00,
        P_4B = 2'b01,
        P_2B = 2'b10
    } p_mode_t;

    // Number of stored entries consumed by one pop in the given mode.
    function automatic logic [2:0] entries_per_pop(input p_mode_t mode);
        case (mode)
            P_4B:    return 3'd2;
            P_2B:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/miso_fifo_pack_if.sv
// Bus bundle for miso_fifo_pack: write lanes, pop/replay controls and status.
// The master drives the requests, the slave (the FIFO) drives the results.
interface miso_fifo_pack_if #(
    parameter int DEPTH       = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                                   i_clear;
    logic                                   i_write_en;
    logic [DATA_LENGTH-1:0]                 i_valid;
    logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] i_data;
    logic                                   i_pop_en;
    logic [1:0]                             i_p_mode;
    logic                                   i_r_pointer_reset;
    logic                                   i_release;

    logic [DATA_WIDTH-1:0]                  o_data;
    logic                                   o_pop_valid;
    logic                                   o_wr_reject;
    logic                                   o_empty;
    logic                                   o_full;
    logic [CW-1:0]                          o_count;
    logic [CW-1:0]                          o_avail;

    modport master (
        output i_clear, i_write_en, i_valid, i_data, i_pop_en, i_p_mode,
               i_r_pointer_reset, i_release,
        input  o_data, o_pop_valid, o_wr_reject, o_empty, o_full, o_count,
               o_avail
    );

    modport slave (
        input  i_clear, i_write_en, i_valid, i_data, i_pop_en, i_p_mode,
               i_r_pointer_reset, i_release,
        output o_data, o_pop_valid, o_wr_reject, o_empty, o_full, o_count,
               o_avail
    );

endinterface

// File: rtl/miso_fifo_pack_lane_compactor.sv
// Lane compactor: squeezes the valid lanes of a sparse write down to slots
// 0..k-1, keeping ascending lane order, and reports k.
module miso_fifo_pack_lane_compactor #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 8
) (
    input  logic [DATA_LENGTH-1:0]                 i_valid,
    input  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] i_data,
    output logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] o_data,
    output logic [DATA_LENGTH-1:0]                 o_slot_valid,
    output logic [$clog2(DATA_LENGTH+1)-1:0]       o_count
);
    localparam int KW = $clog2(DATA_LENGTH + 1);
    localparam int SW = $clog2(DATA_LENGTH);

    logic [KW-1:0] slot;

    // Walk the lanes in order; each valid lane takes the next free slot.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_data       = '0;
        o_slot_valid = '0;
        slot         = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (i_valid[i]) begin
                o_data[slot[SW-1:0]]       = i_data[i];
                o_slot_valid[slot[SW-1:0]] = 1'b1;
                slot                       = slot + 1'b1;
            end
        end
        o_count = slot;
    end

endmodule

// File: rtl/miso_fifo_pack.sv
// Replay-capable multi-input / single-output FIFO. Sparse writes are
// compacted and stored in arrival order; each pop packs 1, 2 or 4 entries
// into one output word. Popped data stays replayable until released.
module miso_fifo_pack
    import miso_fifo_pack_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 8
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    miso_fifo_pack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(DATA_LENGTH + 1);
    localparam int HW = DATA_WIDTH / 2;
    localparam int QW = DATA_WIDTH / 4;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr, rd_ptr, base_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] comp_data;
    logic [DATA_LENGTH-1:0]                 comp_valid;
    logic [KW-1:0]                          comp_cnt;

    logic [PW-1:0]         used, unread, free_space;
    p_mode_t               pop_mode;
    logic [2:0]            pop_n;
    logic                  write_req, write_ok, write_drop;
    logic                  pop_ok, release_ok;
    logic [AW-1:0]         rd_addr [4];
    logic [DATA_WIDTH-1:0] pop_word;

    miso_fifo_pack_lane_compactor #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DATA_LENGTH (DATA_LENGTH)
    ) u_compactor (
        .i_valid      (bus.i_valid),
        .i_data       (bus.i_data),
        .o_data       (comp_data),
        .o_slot_valid (comp_valid),
        .o_count      (comp_cnt)
    );

    // Occupancy is measured from base (replayable data still holds space);
    // availability is measured from rd.
    assign used       = wr_ptr - base_ptr;
    assign unread     = wr_ptr - rd_ptr;
    assign free_space = PW'(DEPTH) - used;

    // The reserved mode code behaves as full-width entries.
    assign pop_mode = (bus.i_p_mode == 2'b11) ? P_8B : p_mode_t'(bus.i_p_mode);
    assign pop_n    = entries_per_pop(pop_mode);

    // Clear overrides everything; rewind blocks pop and release but not write.
    assign write_req  = bus.i_write_en && (comp_cnt != '0) && !bus.i_clear;
    assign write_ok   = write_req && (PW'(comp_cnt) <= free_space);
    assign write_drop = write_req && !(PW'(comp_cnt) <= free_space);
    assign pop_ok     = bus.i_pop_en && !bus.i_clear && !bus.i_r_pointer_reset
                        && (unread >= PW'(pop_n));
    assign release_ok = bus.i_release && !bus.i_clear && !bus.i_r_pointer_reset;

    // Gather up to four consecutive entries at rd and pack their low fields.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            rd_addr[j] = rd_ptr[AW-1:0] + AW'(j);
        end
        pop_word = mem[rd_addr[0]];
        case (pop_n)
            3'd2: pop_word = {mem[rd_addr[1]][HW-1:0], mem[rd_addr[0]][HW-1:0]};
            3'd4: pop_word = {mem[rd_addr[3]][QW-1:0], mem[rd_addr[2]][QW-1:0],
                              mem[rd_addr[1]][QW-1:0], mem[rd_addr[0]][QW-1:0]};
            default: pop_word = mem[rd_addr[0]];
        endcase
    end

    // Pointer update: clear, then rewind, then release/pop/write together.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        // NOTE: state registers use non-blocking assignments so every pointer
        // update below sees the pre-edge values of the others.
        if (!i_nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            base_ptr <= '0;
        end else if (bus.i_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            base_ptr <= '0;
        end else begin
            if (bus.i_r_pointer_reset) begin
                rd_ptr <= base_ptr;
            end else begin
                if (release_ok) base_ptr <= rd_ptr;
                if (pop_ok)     rd_ptr   <= rd_ptr + PW'(pop_n);
            end
            if (write_ok) wr_ptr <= wr_ptr + PW'(comp_cnt);
        end
    end

    // Store the compacted slots at wr, wr+1, ... in slot order.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array has no reset; only the pointers define
        // which entries are meaningful, so clearing the array buys nothing.
        if (write_ok) begin
            for (int j = 0; j < DATA_LENGTH; j++) begin
                if (comp_valid[j]) mem[wr_ptr[AW-1:0] + AW'(j)] <= comp_data[j];
            end
        end
    end

    // Registered pop word and the one-cycle valid/reject pulses.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            bus.o_data      <= '0;
            bus.o_pop_valid <= 1'b0;
            bus.o_wr_reject <= 1'b0;
        end else begin
            bus.o_pop_valid <= pop_ok;
            bus.o_wr_reject <= write_drop;
            if (pop_ok) bus.o_data <= pop_word;
        end
    end

    assign bus.o_empty = (wr_ptr == rd_ptr);
    assign bus.o_full  = (used == PW'(DEPTH));
    assign bus.o_count = CW'(used);
    assign bus.o_avail = CW'(unread);

endmodule

// File: tb/tb_miso_fifo_pack.sv
// Self-checking bench for miso_fifo_pack: a table of directed vectors,
// hand-written multi-cycle sequences, and a randomized run against a
// queue-based reference model.
module tb_miso_fifo_pack;

    localparam int DEPTH = 32;
    localparam int DW    = 8;
    localparam int DL    = 8;

    logic i_clk;
    logic i_nrst;

    miso_fifo_pack_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .DATA_LENGTH(DL)) bus ();

    miso_fifo_pack #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .DATA_LENGTH(DL)) dut (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .bus    (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [7:0]  valid;
        logic [63:0] data;
        logic        pop;
        logic [1:0]  mode;
        logic        clr;
        logic        rr;
        logic        rel;
        logic        e_pv;
        logic [7:0]  e_data;
        logic        e_rej;
        logic        e_empty;
        logic        e_full;
        logic [5:0]  e_count;
        logic [5:0]  e_avail;
    } vec_t;

    vec_t vecs[$];

    // Reference model: entries from base to wr, and how many have been read.
    logic [7:0] m_q[$];
    int         m_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] valid, input logic [63:0] data,
                                input logic pop, input logic [1:0] mode, input logic clr,
                                input logic rr, input logic rel, input logic e_pv,
                                input logic [7:0] e_data, input logic e_rej, input logic e_empty,
                                input logic e_full, input logic [5:0] e_count,
                                input logic [5:0] e_avail);
        vec_t v;
        v.we = we; v.valid = valid; v.data = data; v.pop = pop; v.mode = mode;
        v.clr = clr; v.rr = rr; v.rel = rel; v.e_pv = e_pv; v.e_data = e_data;
        v.e_rej = e_rej; v.e_empty = e_empty; v.e_full = e_full;
        v.e_count = e_count; v.e_avail = e_avail;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [7:0] valid, input logic [63:0] data,
                         input logic pop, input logic [1:0] mode, input logic clr,
                         input logic rr, input logic rel);
        bus.i_write_en        = we;
        bus.i_valid           = valid;
        bus.i_data            = data;
        bus.i_pop_en          = pop;
        bus.i_p_mode          = mode;
        bus.i_clear           = clr;
        bus.i_r_pointer_reset = rr;
        bus.i_release         = rel;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cycle(input logic we, input logic [7:0] valid, input logic [63:0] data,
                         input logic pop, input logic [1:0] mode, input logic clr,
                         input logic rr, input logic rel);
        drive(we, valid, data, pop, mode, clr, rr, rel);
        tick();
        drive(0, 8'h00, 64'h0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic check_status(input string tag, input logic [5:0] cnt, input logic [5:0] av,
                                input logic empty, input logic full);
        check({tag, ".count"}, 64'(bus.o_count), 64'(cnt));
        check({tag, ".avail"}, 64'(bus.o_avail), 64'(av));
        check({tag, ".empty"}, 64'(bus.o_empty), 64'(empty));
        check({tag, ".full"},  64'(bus.o_full),  64'(full));
    endtask

    task automatic check_pop(input string tag, input logic pv, input logic [7:0] data);
        check({tag, ".pop_valid"}, 64'(bus.o_pop_valid), 64'(pv));
        if (pv) check({tag, ".data"}, 64'(bus.o_data), 64'(data));
    endtask

    // One model cycle, derived from the FIFO rules rather than the RTL.
    task automatic model_cycle(input logic we, input logic [7:0] valid, input logic [63:0] data,
                               input logic pop, input logic [1:0] mode, input logic clr,
                               input logic rr, input logic rel,
                               output logic e_pv, output logic [7:0] e_data, output logic e_rej);
        int p;
        int free_n;
        int k;
        int avail;
        int word;
        p      = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
        e_pv   = 1'b0;
        e_data = 8'h00;
        e_rej  = 1'b0;
        if (clr) begin
            m_q.delete();
            m_rd = 0;
        end else begin
            free_n = DEPTH - m_q.size();
            k      = $countones(valid);
            avail  = m_q.size() - m_rd;
            if (rr) begin
                m_rd = 0;
            end else begin
                if (rel) begin
                    repeat (m_rd) void'(m_q.pop_front());
                    m_rd = 0;
                end
                if (pop && avail >= p) begin
                    word = 0;
                    for (int j = 0; j < p; j++) begin
                        word = word | ((int'(m_q[m_rd + j]) & ((1 << (8 / p)) - 1)) << (j * (8 / p)));
                    end
                    e_pv   = 1'b1;
                    e_data = word[7:0];
                    m_rd   = m_rd + p;
                end
            end
            if (we && k > 0) begin
                if (k <= free_n) begin
                    for (int l = 0; l < DL; l++) begin
                        if (valid[l]) m_q.push_back(data[8*l +: 8]);
                    end
                end else begin
                    e_rej = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_we, r_pop, r_clr, r_rr, r_rel;
        logic [7:0]  r_valid;
        logic [63:0] r_data;
        logic [1:0]  r_mode;
        logic        e_pv, e_rej;
        logic [7:0]  e_data;

        // ---------------- reset ----------------
        i_nrst = 1'b0;
        drive(0, 8'h00, 64'h0, 0, 2'b00, 0, 0, 0);
        repeat (3) tick();
        check("reset.data", 64'(bus.o_data), 64'h0);
        check("reset.pop_valid", 64'(bus.o_pop_valid), 64'h0);
        check("reset.wr_reject", 64'(bus.o_wr_reject), 64'h0);
        check_status("reset", 6'd0, 6'd0, 1'b1, 1'b0);
        i_nrst = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        // mode 00
        vecs.push_back(mk(1, 8'h03, 64'h2211, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 64'h0,    1, 2'd0, 0, 0, 0, 1, 8'h11, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 8'h00, 64'h0,    1, 2'd0, 0, 0, 0, 1, 8'h22, 0, 1, 0, 2, 0));
        vecs.push_back(mk(0, 8'h00, 64'h0,    1, 2'd0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 2, 0));
        vecs.push_back(mk(0, 8'h00, 64'h0,    0, 2'd0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0));
        // mode 01
        vecs.push_back(mk(1, 8'h1F, 64'h0504030201, 0, 2'd1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 5, 5));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd1, 0, 0, 0, 1, 8'h21, 0, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd1, 0, 0, 0, 1, 8'h43, 0, 0, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 64'h0, 0, 2'd1, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0));
        // mode 10
        vecs.push_back(mk(1, 8'h7F, 64'h01010101010101, 0, 2'd2, 0, 0, 0, 0, 8'h00, 0, 0, 0, 7, 7));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd2, 0, 0, 0, 1, 8'h55, 0, 0, 0, 7, 3));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd2, 0, 0, 0, 0, 8'h00, 0, 0, 0, 7, 3));
        vecs.push_back(mk(0, 8'h00, 64'h0, 0, 2'd2, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0));
        // sparse mask: lanes 0, 2, 5, 7 stored in order
        vecs.push_back(mk(1, 8'hA5, 64'hA7A6A5A4A3A2A1A0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 4, 4));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0, 1, 8'hA0, 0, 0, 0, 4, 3));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0, 1, 8'hA2, 0, 0, 0, 4, 2));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0, 1, 8'hA5, 0, 0, 0, 4, 1));
        vecs.push_back(mk(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0, 1, 8'hA7, 0, 1, 0, 4, 0));
        vecs.push_back(mk(0, 8'h00, 64'h0, 0, 2'd0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 0));
        // reserved mode, rewind vs pop, release+pop, release+pop+write
        vecs.push_back(mk(1, 8'h03, 64'hC33C, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 64'h0,    1, 2'd3, 0, 0, 0, 1, 8'h3C, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 8'h00, 64'h0,    1, 2'd0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 64'h0,    1, 2'd0, 0, 0, 1, 1, 8'h3C, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, 8'h01, 64'h5A,   1, 2'd0, 0, 0, 1, 1, 8'hC3, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 8'h00, 64'h0,    0, 2'd0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].valid, vecs[i].data, vecs[i].pop, vecs[i].mode,
                  vecs[i].clr, vecs[i].rr, vecs[i].rel);
            check_pop($sformatf("vec%0d", i), vecs[i].e_pv, vecs[i].e_data);
            check($sformatf("vec%0d.wr_reject", i), 64'(bus.o_wr_reject), 64'(vecs[i].e_rej));
            check_status($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_avail,
                         vecs[i].e_empty, vecs[i].e_full);
        end

        // ---------------- rejection and full boundary ----------------
        repeat (3) cycle(1, 8'hFF, 64'h8786858483828180, 0, 2'd0, 0, 0, 0);
        cycle(1, 8'h3F, 64'h8786858483828180, 0, 2'd0, 0, 0, 0);
        check_status("fill30", 6'd30, 6'd30, 1'b0, 1'b0);
        cycle(1, 8'h0F, 64'h8786858483828180, 0, 2'd0, 0, 0, 0);
        check("rej4.wr_reject", 64'(bus.o_wr_reject), 64'h1);
        check_status("rej4", 6'd30, 6'd30, 1'b0, 1'b0);
        cycle(0, 8'h00, 64'h0, 0, 2'd0, 0, 0, 0);
        check("rej_pulse_end", 64'(bus.o_wr_reject), 64'h0);
        cycle(1, 8'h01, 64'h80, 0, 2'd0, 0, 0, 0);
        check_status("fill31", 6'd31, 6'd31, 1'b0, 1'b0);
        cycle(1, 8'h01, 64'h80, 0, 2'd0, 0, 0, 0);
        check_status("fill32", 6'd32, 6'd32, 1'b0, 1'b1);
        cycle(1, 8'h00, 64'h80, 0, 2'd0, 0, 0, 0);
        check("zero_mask.wr_reject", 64'(bus.o_wr_reject), 64'h0);
        cycle(1, 8'h01, 64'h80, 1, 2'd0, 0, 0, 0);
        check("full_write.wr_reject", 64'(bus.o_wr_reject), 64'h1);
        check_pop("full_pop", 1'b1, 8'h80);
        cycle(1, 8'h01, 64'h80, 1, 2'd0, 1, 0, 0);
        check("clear.pop_valid", 64'(bus.o_pop_valid), 64'h0);
        check("clear.wr_reject", 64'(bus.o_wr_reject), 64'h0);
        check_status("clear", 6'd0, 6'd0, 1'b1, 1'b0);

        // ---------------- replay and release ----------------
        cycle(1, 8'h0F, 64'h40302010, 0, 2'd0, 0, 0, 0);
        cycle(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0);
        check_pop("replay.p0", 1'b1, 8'h10);
        cycle(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0);
        check_pop("replay.p1", 1'b1, 8'h20);
        check_status("replay.pre", 6'd4, 6'd2, 1'b0, 1'b0);
        cycle(0, 8'h00, 64'h0, 0, 2'd0, 0, 1, 0);
        check_status("replay.rewind", 6'd4, 6'd4, 1'b0, 1'b0);
        cycle(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0);
        check_pop("replay.r0", 1'b1, 8'h10);
        cycle(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0);
        check_pop("replay.r1", 1'b1, 8'h20);
        cycle(0, 8'h00, 64'h0, 0, 2'd0, 0, 1, 0);
        cycle(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0);
        check_pop("replay.s0", 1'b1, 8'h10);
        cycle(0, 8'h00, 64'h0, 0, 2'd0, 0, 0, 1);
        check_status("release", 6'd3, 6'd3, 1'b0, 1'b0);
        cycle(0, 8'h00, 64'h0, 1, 2'd0, 0, 0, 0);
        check_pop("release.next", 1'b1, 8'h20);

        // ---------------- asynchronous reset mid-operation ----------------
        i_nrst = 1'b0;
        #1;
        check("async_rst.pop_valid", 64'(bus.o_pop_valid), 64'h0);
        check("async_rst.data", 64'(bus.o_data), 64'h0);
        check_status("async_rst", 6'd0, 6'd0, 1'b1, 1'b0);
        tick();
        i_nrst = 1'b1;
        tick();

        // ---------------- wrap with write+pop+release every cycle ----------------
        for (int i = 0; i < 80; i++) begin
            cycle(1, 8'h01, 64'(i), 1, 2'd0, 0, 0, 1);
            check($sformatf("wrap%0d.pop_valid", i), 64'(bus.o_pop_valid), 64'(i >= 1));
            if (i >= 1) check($sformatf("wrap%0d.data", i), 64'(bus.o_data), 64'(i - 1));
            check($sformatf("wrap%0d.wr_reject", i), 64'(bus.o_wr_reject), 64'h0);
        end

        // ---------------- randomized run against the model ----------------
        m_q.delete();
        m_rd = 0;
        for (int c = 0; c < 1500; c++) begin
            r_we    = 1'($urandom_range(1, 0));
            r_valid = 8'($urandom & $urandom);
            r_data  = {$urandom, $urandom};
            r_pop   = ($urandom_range(2, 0) != 0);
            r_mode  = 2'($urandom_range(3, 0));
            r_clr   = (c == 0) || ($urandom_range(96, 0) == 0);
            r_rr    = ($urandom_range(22, 0) == 0);
            r_rel   = ($urandom_range(4, 0) == 0);
            model_cycle(r_we, r_valid, r_data, r_pop, r_mode, r_clr, r_rr, r_rel,
                        e_pv, e_data, e_rej);
            cycle(r_we, r_valid, r_data, r_pop, r_mode, r_clr, r_rr, r_rel);
            check_pop($sformatf("rnd%0d", c), e_pv, e_data);
            check($sformatf("rnd%0d.wr_reject", c), 64'(bus.o_wr_reject), 64'(e_rej));
            check_status($sformatf("rnd%0d", c), 6'(m_q.size()), 6'(m_q.size() - m_rd),
                         (m_q.size() - m_rd) == 0, m_q.size() == DEPTH);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/miso_fifo_pack.md
# miso_fifo_pack

Replay-capable multi-input / single-output FIFO for the sequential router memory path. Accepts up to DATA_LENGTH sparse lanes per write, compacts the valid ones and stores them in arrival order. Emits one DATA_WIDTH word per pop, packing 1, 2 or 4 stored entries according to the precision mode. A base pointer keeps popped data replayable until it is explicitly released.

## Interface
- DEPTH, 32, entries; power of two, ≥ DATA_LENGTH
- DATA_WIDTH, 8, bits per entry and per output word; divisible by 4
- DATA_LENGTH, 8, input lanes per write
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous flush of all pointers
- i_write_en  in  1  write request
- i_valid  in  DATA_LENGTH  per-lane valid mask
- i_data  in  DATA_LENGTH×DATA_WIDTH  lane data, packed array
- i_pop_en  in  1  pop request
- i_p_mode  in  2  precision mode: 00 = 8b (P=1), 01 = 4b (P=2), 10 = 2b (P=4), 11 = reserved (treated as 00)
- i_r_pointer_reset  in  1  rewind read pointer to base pointer (replay)
- i_release  in  1  free entries already read: base pointer ← read pointer
- o_data  out  DATA_WIDTH  packed pop word
- o_pop_valid  out  1  o_data valid, one-cycle pulse
- o_wr_reject  out  1  previous write was dropped, one-cycle pulse
- o_empty  out  1  no unread entries (rd == wr)
- o_full  out  1  occupancy == DEPTH
- o_count  out  $clog2(DEPTH+1)  occupancy (wr − base)
- o_avail  out  $clog2(DEPTH+1)  unread entries (wr − rd)

## Operation
- Three pointers (wr, rd, base), each $clog2(DEPTH)+1 bits; the MSB disambiguates wrap. Storage address = pointer[$clog2(DEPTH)-1:0].
- Write: k = popcount(i_valid). Accept if DEPTH − o_count ≥ k. Valid lanes go to wr, wr+1, … in ascending lane order; wr += k. Otherwise drop the whole write: nothing written, o_wr_reject = 1 next cycle. If k = 0, no-op with no reject.
- Pop: accept if o_avail ≥ P for the current i_p_mode. Entry j (j = 0..P−1, read from rd+j) supplies bits [DATA_WIDTH/P−1:0] into o_data[j·DATA_WIDTH/P +: DATA_WIDTH/P]; rd += P. If o_avail < P, the pop is ignored: o_pop_valid stays 0 and no pointer moves. No partial pops.
- Priority, same cycle: i_clear > i_r_pointer_reset > (pop, release, write).
  - i_clear: wr = rd = base = 0.
  - i_r_pointer_reset: rd ← base; a concurrent pop is ignored; a concurrent write proceeds.
  - Release with pop: base ← pre-pop rd, then the pop advances rd.
- Pop and write in the same cycle: availability uses the pre-write wr. Free space uses the pre-release base.
- Storage contents are not cleared by reset or i_clear.

## Timing
- Reset values: o_data = 0, o_pop_valid = 0, o_wr_reject = 0, o_empty = 1, o_full = 0, o_count = 0, o_avail = 0; all pointers = 0.
- Pop latency 1: pop accepted at edge n gives o_data and o_pop_valid at n+1. o_pop_valid is high only in cycles following an accepted pop. Back-to-back pops give one word per cycle.
- A write at edge n is poppable at edge n+1.
- o_empty, o_full, o_count and o_avail are combinational from the registered pointers.
- i_clear at edge n forces o_pop_valid = 0 and o_wr_reject = 0 at n+1.
- i_nrst assertion mid-operation immediately zeroes all outputs and pointers.
- i_p_mode is sampled per pop. Changing it with o_avail mod P ≠ 0 is legal; a residue smaller than P is simply not poppable.

## Structure
- Shared router package holds:
  - p_mode_t enum (P_8B, P_4B, P_2B)
  - function entries_per_pop(p_mode_t) returning 1/2/4
- Sub-module lane_compactor (combinational): i_valid and i_data in; compacted data, per-slot valid and count k out.
- Top level holds the pointers, storage array, pop packer and output registers.

## Test plan
- Mode 00: write lanes 0–1 = 8'h11, 8'h22, then pop 3 cycles → o_data 8'h11, then 8'h22; third pop ignored; o_empty = 1.
- Mode 01: write 8'h01–8'h05 in lanes 0–4, pop 3 cycles → 8'h21, 8'h43, third ignored; o_avail = 1.
- Mode 10: write 8'h01 in lanes 0–6, pop 2 cycles → 8'h55, second ignored; o_avail = 3. Then i_clear → o_count = 0, o_empty = 1.
- Sparse mask and rejection:
  - i_valid = 8'b1010_0101 → entries stored as lanes 0, 2, 5, 7 in order.
  - With DEPTH = 32 and o_count = 30, a 4-valid write → o_wr_reject pulse, o_count stays 30.
- Replay: write 4, pop 2, assert i_r_pointer_reset → o_avail = 4 and the same two words pop again. Then i_release after one pop → o_count = 3.
- Wrap and simultaneity: cycle >2×DEPTH entries with a concurrent write+pop each cycle → data order preserved across wrap; o_full asserts exactly at 32.
